gpo_disp_scan: RTL and testbench
================================

# gpo_disp_scan

Time-multiplexed eight-digit seven-segment scanner that consumes the two GPIO output registers. GPO1 supplies eight hex nibbles; GPO2 supplies per-digit enable, decimal-point and mode control. The block snapshots both words once per frame for tear-free display, then drives active-low anode and cathode lines with an anti-ghost blanking gap at the start of every digit slot.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range 2..2^20.
- BLANK, 4: cycles at the start of each slot with all anodes off; legal range 1..DIV-1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  32  display value from GPO1; nibble i (data[4i+3:4i]) feeds digit i, digit 0 rightmost.
- ctrl  in  32  control word from GPO2:
  - [7:0] digit enable, 1 = lit.
  - [15:8] decimal point per digit, 1 = lit.
  - [16] leading-zero blanking enable.
  - [17] freeze: no snapshot while set.
  - [31:18] ignored.
- an  out  8  anodes, active-low, one-hot-low or all-high.
- seg  out  7  cathodes, active-low, seg[0]=a ... seg[6]=g.
- dp  out  1  decimal-point cathode, active-low.
- digit_idx  out  3  digit index currently being scanned (unregistered copy of the state).
- frame_done  out  1  one-cycle pulse at the end of each 8-digit frame.

## Operation
- State:
  - Prescaler cnt, 0..DIV-1, increments every cycle.
  - idx, 0..7, advances when cnt==DIV-1; 7 wraps to 0.
  - Shadow registers sdata[31:0] and sctrl[17:0].
- Snapshot:
  - Occurs in any cycle with cnt==0, idx==0 and ctrl[17]==0; sdata<=data, sctrl<=ctrl[17:0].
  - With ctrl[17]==1 the old shadows persist for the whole frame.
  - The freeze bit is sampled live, not from the shadow.
- Digit visibility, evaluated on shadows: digit i is visible when sctrl[i]==1, and not (sctrl[16]==1 and i!=0 and sdata[31:4i]==0). Digit 0 is never zero-blanked.
- Hex decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Registered outputs, computed from the state in the previous cycle:
  - If cnt<BLANK or the digit is not visible: an=8'hFF, seg=7'h7F, dp=1.
  - Otherwise: an=~(1<<idx), seg=decode(sdata nibble idx), dp=~sctrl[8+idx].
- A non-visible digit still consumes its full DIV-cycle slot; scan rate is constant.
- Reset values:
  - cnt=0, idx=0, sdata=0, sctrl=0.
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
  - First snapshot happens in the first cycle after rst deasserts.
- Reset mid-frame: all outputs go blank immediately (asynchronous); the scan restarts at digit 0 with a fresh snapshot.

## Timing
- Digit slot = DIV cycles; frame = 8*DIV cycles; lit portion of a slot = DIV-BLANK cycles.
- Output latency = 1 cycle from state to an/seg/dp.
- Within slot k, the digit is lit from cycle BLANK+1 through cycle DIV of that slot, counted relative to the edge where cnt becomes 0.
- A snapshot taken at cnt==0 is first visible at cnt==BLANK+1. Since BLANK>=1, the blanking gap masks the shadow update and no mixed-frame digit is ever driven.
- frame_done=1 for exactly the one cycle after the edge on which idx=7 and cnt=DIV-1; it coincides with the snapshot cycle of the next frame.
- data/ctrl changes outside the snapshot cycle have no effect until the next frame.

## Test plan
- Common setup: DIV=8, BLANK=2 for all scenarios.
- Reset blanking: rst high, then release with data=32'h12345678, ctrl=32'h000000FF.
  - During the first 3 cycles: an=FF, seg=7F.
  - Cycle 3: an=FE, seg=0000000 (8).
  - After 8 more cycles: an=FD, seg=1111000 (7).
- Frame pulse: free-run.
  - frame_done pulses every 64 cycles, width 1.
  - digit_idx sequence is 0..7, each value held 8 cycles.
- Tear-free: change data to 32'hFFFFFFFF mid-frame at idx=3.
  - Digits 4..7 still show 4,3,2,1.
  - The next frame shows F on all digits.
- Leading-zero blanking: data=32'h00000A05, ctrl=32'h000100FF.
  - Digits 3..7 stay an=FF for their slots.
  - Digit 2 shows A=0001000, digit 1 shows 0, digit 0 shows 5.
- Freeze and decimal point:
  - Snapshot data=32'h00000001, ctrl=32'h00020101.
  - Then set data=32'h2; digit 0 keeps showing 1 with dp=0 across 3 frames.
  - Clear bit 17; the next frame shows 2.
- Mid-frame reset: pulse rst while idx=5, cnt=4.
  - an=FF, seg=7F, dp=1 in the same cycle.
  - After release, the scan restarts at idx=0.

Source files
------------

// File: rtl/gpo_disp_scan.sv
// gpo_disp_scan: eight-digit seven-segment scanner fed by the two GPIO output
// registers. Data and control are captured once per frame into shadow
// registers so a digit never shows a mix of old and new values, and every
// digit slot opens with a short all-anodes-off gap to suppress ghosting.
module gpo_disp_scan #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [31:0] ctrl,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(DIV - 1);
  localparam logic [CW-1:0] CntBlank = CW'(BLANK);

  // Active-low hex font, bit order g..a.
  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [17:0]   sctrl_q, sctrl_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          slotEnd;
  logic          snapshot;
  logic [31:0]   shifted;
  logic [7:0]    dpBits;
  logic          lzBlank;
  logic          visible;

  // The top bits of the control word are reserved, and the stored freeze bit
  // is never read back because freeze acts on the live input.
  logic unused_bits;
  assign unused_bits = ^{ctrl[31:18], sctrl_q[17]};

  // Next-state for the scan counters and shadows, plus the output word the
  // current state implies (registered below for a clean one-cycle latency).
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sdata_d      = sdata_q;
    sctrl_d      = sctrl_q;
    an_d         = 8'hFF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = 1'b0;

    slotEnd = (cnt_q == CntLast);
    if (slotEnd) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    snapshot = (cnt_q == '0) && (idx_q == 3'd0) && !ctrl[17];
    if (snapshot) begin
      sdata_d = data;
      sctrl_d = ctrl[17:0];
    end

    shifted = sdata_q >> {idx_q, 2'b00};
    dpBits  = sctrl_q[15:8];
    lzBlank = sctrl_q[16] && (idx_q != 3'd0) && (shifted == 32'd0);
    visible = sctrl_q[idx_q] && !lzBlank;

    if ((cnt_q >= CntBlank) && visible) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = hexDecode(shifted[3:0]);
      dp_d  = ~dpBits[idx_q];
    end

    frame_done_d = slotEnd && (idx_q == 3'd7);
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      sdata_q      <= 32'd0;
      sctrl_q      <= 18'd0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sdata_q      <= sdata_d;
      sctrl_q      <= sctrl_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gpo_disp_scan.sv
// tb_gpo_disp_scan: drives the scanner through directed display scenarios and
// randomized data/control traffic, checking every cycle against a reference
// model that derives scan position from the elapsed cycle count.
module tb_gpo_disp_scan;

   localparam int DIV   = 8;
   localparam int BLANK = 2;

   logic        clk;
   logic        rst;
   logic [31:0] data;
   logic [31:0] ctrl;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [2:0]  digit_idx;
   logic        frame_done;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: edges since reset release plus the frame shadows.
   int          n;
   logic [31:0] mData;
   logic [17:0] mCtrl;
   logic [7:0]  expAn;
   logic [6:0]  expSeg;
   logic        expDp;
   logic        expFd;

   logic [6:0] hexTable [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   gpo_disp_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .ctrl       (ctrl),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the scenario sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      n      = 0;
      mData  = 32'd0;
      mCtrl  = 18'd0;
      expAn  = 8'hFF;
      expSeg = 7'h7F;
      expDp  = 1'b1;
      expFd  = 1'b0;
   endtask

   // One rising edge of the reference: outputs follow from where the scan is
   // within its frame, then the frame-start snapshot is applied.
   task automatic modelEdge();
      int   cnt;
      int   idx;
      logic zeroAbove;
      logic vis;
      cnt = n % DIV;
      idx = (n / DIV) % 8;
      zeroAbove = 1'b1;
      for (int j = idx; j < 8; j++) begin
         if (mData[4*j +: 4] != 4'd0) zeroAbove = 1'b0;
      end
      vis = mCtrl[idx] && !(mCtrl[16] && idx != 0 && zeroAbove);
      if (cnt < BLANK || !vis) begin
         expAn  = 8'hFF;
         expSeg = 7'h7F;
         expDp  = 1'b1;
      end else begin
         expAn  = ~(8'h01 << idx);
         expSeg = hexTable[mData[4*idx +: 4]];
         expDp  = ~mCtrl[8+idx];
      end
      expFd = (idx == 7) && (cnt == DIV - 1);
      if (cnt == 0 && idx == 0 && !ctrl[17]) begin
         mData = data;
         mCtrl = ctrl[17:0];
      end
      n++;
   endtask

   task automatic checkAll();
      checkOutput("an", 32'(an), 32'(expAn));
      checkOutput("seg", 32'(seg), 32'(expSeg));
      checkOutput("dp", 32'(dp), 32'(expDp));
      checkOutput("digit_idx", 32'(digit_idx), 32'((n / DIV) % 8));
      checkOutput("frame_done", 32'(frame_done), 32'(expFd));
   endtask

   // Advance one clock: model on the rising edge, compare on the falling edge.
   task automatic applyStimulus(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         modelEdge();
         @(negedge clk);
         checkAll();
      end
   endtask

   // Advance until the scan sits at the requested digit and prescaler value.
   task automatic waitScan(input int targetIdx, input int targetCnt);
      int budget;
      budget = 0;
      while (!((n % DIV) == targetCnt && ((n / DIV) % 8) == targetIdx) && budget < 200) begin
         applyStimulus(1);
         budget++;
      end
      if (budget >= 200) checkOutput("wait_timeout", 32'd0, 32'd1);
   endtask

   // Asynchronous reset pulse issued between clock edges.
   task automatic applyReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_an", 32'(an), 32'h0000_00FF);
      checkOutput("rst_seg", 32'(seg), 32'h0000_007F);
      checkOutput("rst_dp", 32'(dp), 32'd1);
      checkOutput("rst_fd", 32'(frame_done), 32'd0);
      checkOutput("rst_idx", 32'(digit_idx), 32'd0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      checkAll();
   endtask

   initial begin
      int gap;
      int pulses;
      int shiftAmt;
      rst  = 1'b1;
      data = 32'd0;
      ctrl = 32'd0;
      modelReset();
      @(negedge clk);
      checkAll();

      // Reset release with a fully enabled display.
      data = 32'h1234_5678;
      ctrl = 32'h0000_00FF;
      @(negedge clk);
      rst = 1'b0;
      checkAll();
      applyStimulus(1);
      checkOutput("rel_an1", 32'(an), 32'h0000_00FF);
      applyStimulus(1);
      checkOutput("rel_an2", 32'(an), 32'h0000_00FF);
      applyStimulus(1);
      checkOutput("rel_an3", 32'(an), 32'h0000_00FE);
      checkOutput("rel_seg3", 32'(seg), 32'(7'b0000000));
      applyStimulus(8);
      checkOutput("rel_an11", 32'(an), 32'h0000_00FD);
      checkOutput("rel_seg11", 32'(seg), 32'(7'b1111000));

      // Frame pulse spacing measured independently of the model.
      gap    = 0;
      pulses = 0;
      for (int k = 0; k < 200; k++) begin
         applyStimulus(1);
         gap++;
         if (frame_done) begin
            if (pulses > 0) checkOutput("fd_period", 32'(gap), 32'd64);
            pulses++;
            gap = 0;
         end
      end
      checkOutput("fd_count", 32'(pulses), 32'd3);

      // Tear-free: a mid-frame data change waits for the next frame.
      waitScan(3, 0);
      data = 32'hFFFF_FFFF;
      applyStimulus(140);

      // Leading-zero blanking.
      data = 32'h0000_0A05;
      ctrl = 32'h0001_00FF;
      applyStimulus(140);

      // Freeze holds the old shadows, decimal point on digit 0.
      data = 32'h0000_0001;
      ctrl = 32'h0000_0101;
      applyStimulus(70);
      ctrl = 32'h0002_0101;
      data = 32'h0000_0002;
      applyStimulus(192);
      ctrl = 32'h0000_0101;
      applyStimulus(140);

      // Mid-frame reset at digit 5, prescaler 4.
      data = 32'h8765_4321;
      ctrl = 32'h0000_A5FF;
      applyStimulus(64);
      waitScan(5, 4);
      checkOutput("pre_rst_an", 32'(an), 32'h0000_00DF);
      applyReset();
      applyStimulus(70);

      // Randomized traffic including freeze, blanking and decimal points.
      for (int it = 0; it < 40; it++) begin
         data = $urandom;
         if ($urandom_range(1, 0) == 1) begin
            shiftAmt = 4 * $urandom_range(7, 1);
            data = data >> shiftAmt;
         end
         ctrl = $urandom;
         if ($urandom_range(3, 0) != 0) ctrl[17] = 1'b0;
         applyStimulus($urandom_range(100, 1));
         if (it == 20) applyReset();
      end
      ctrl[17] = 1'b0;
      applyStimulus(70);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
